// File: rtl/scene_display_controller.sv
// Scene selector for the SPI LCD: muxes one of N_SCENES pixel sources onto the
// LCD data bus and commits scene changes at a frame boundary, with an idle fallback.
module scene_display_controller #(
    parameter int N_SCENES      = 8,
    parameter int DATA_W        = 16,
    parameter int X_W           = 8,
    parameter int Y_W           = 8,
    parameter int LCD_W         = 132,
    parameter int LCD_H         = 162,
    parameter int DEFAULT_SCENE = 0,
    parameter int TIMEOUT_CYC   = 1000000000,
    parameter int SYNC_SWITCH   = 1,
    localparam int SEL_W        = (N_SCENES > 1) ? $clog2(N_SCENES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [X_W-1:0]               addr_x,
    input  logic [Y_W-1:0]               addr_y,
    input  logic [N_SCENES*DATA_W-1:0]   pix_in,
    input  logic [N_SCENES-1:0]          req,
    input  logic                         activity,
    output logic [DATA_W-1:0]            pix_out,
    output logic [SEL_W-1:0]             active_scene,
    output logic [N_SCENES-1:0]          scene_en,
    output logic                         switch_pulse,
    output logic                         timeout_pulse
);

    localparam int ADDR_W = X_W + Y_W;
    localparam int TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [SEL_W-1:0] DEF_C      = SEL_W'(DEFAULT_SCENE);
    localparam logic [TMR_W-1:0] TMR_LAST_C = TMR_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    // The panel geometry must be addressable by the x/y buses handed over by spi_lcd.
    generate
        if ((LCD_W > (1 << X_W)) || (LCD_H > (1 << Y_W))) begin : g_geom_check
            $error("scene_display_controller: LCD geometry exceeds address width");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [SEL_W-1:0]      pending_r;
    logic                  pending_valid_r;
    logic [TMR_W-1:0]      timer_r;
    logic [ADDR_W-1:0]     prev_addr_r;
    logic [SEL_W-1:0]      active_scene_r;
    logic [N_SCENES-1:0]   scene_en_r;
    logic [DATA_W-1:0]     pix_out_r;
    logic                  switch_pulse_r;
    logic                  timeout_pulse_r;

    logic                  any_req_s;
    logic [SEL_W-1:0]      cand_s;
    logic [ADDR_W-1:0]     cur_addr_s;
    logic                  frame_start_s;
    logic                  timeout_s;
    logic                  timer_clr_s;
    logic                  switch_s;
    logic [SEL_W-1:0]      active_nxt_s;
    logic [DATA_W-1:0]     pix_sel_s;

    function automatic logic [N_SCENES-1:0] onehot_f(input logic [SEL_W-1:0] idx);
        logic [N_SCENES-1:0] v;
        for (int i = 0; i < N_SCENES; i++) begin
            v[i] = (SEL_W'(i) == idx);
        end
        return v;
    endfunction

    // Request arbitration (highest index wins), frame-boundary edge and idle timeout.
    always_comb begin
        any_req_s = |req;
        cand_s    = {SEL_W{1'b0}};
        for (int i = 0; i < N_SCENES; i++) begin
            cand_s = req[i] ? SEL_W'(i) : cand_s;
        end
        cur_addr_s    = {addr_y, addr_x};
        frame_start_s = (cur_addr_s == {ADDR_W{1'b0}}) && (prev_addr_r != {ADDR_W{1'b0}});
        timer_clr_s   = activity || any_req_s || (state_r == ST_COMMIT) || (active_scene_r == DEF_C);
        timeout_s     = (TIMEOUT_CYC != 0) && (timer_r == TMR_LAST_C) && !any_req_s
                        && (active_scene_r != DEF_C);
    end

    // Pixel source mux driven by the committed scene.
    always_comb begin
        pix_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_SCENES; i++) begin
            pix_sel_s = (active_scene_r == SEL_W'(i)) ? pix_in[i*DATA_W +: DATA_W] : pix_sel_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_STEADY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_STEADY: begin
                if (pending_valid_r) begin
                    next_state_s = (SYNC_SWITCH != 0) ? ST_WAIT : ST_COMMIT;
                end else begin
                    next_state_s = ST_STEADY;
                end
            end
            ST_WAIT: begin
                if (!pending_valid_r) begin
                    next_state_s = ST_STEADY;
                end else if (frame_start_s) begin
                    next_state_s = ST_COMMIT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_COMMIT: next_state_s = ST_STEADY;
            default:   next_state_s = ST_STEADY;
        endcase
    end

    // FSM outputs: the commit is registered on entry to COMMIT so the pulse and new scene align.
    always_comb begin
        switch_s = (next_state_s == ST_COMMIT);
        if (switch_s) begin
            active_nxt_s = pending_r;
        end else begin
            active_nxt_s = active_scene_r;
        end
    end

    // Pending request, idle timer, committed scene and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r       <= DEF_C;
            pending_valid_r <= 1'b0;
            timer_r         <= {TMR_W{1'b0}};
            prev_addr_r     <= {ADDR_W{1'b0}};
            active_scene_r  <= DEF_C;
            scene_en_r      <= onehot_f(DEF_C);
            pix_out_r       <= {DATA_W{1'b0}};
            switch_pulse_r  <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            prev_addr_r <= cur_addr_s;
            // Arbitrate against the scene that will be active after this edge.
            if (any_req_s) begin
                if (cand_s != active_nxt_s) begin
                    pending_r       <= cand_s;
                    pending_valid_r <= 1'b1;
                end else begin
                    pending_valid_r <= 1'b0;
                end
            end else if (timeout_s) begin
                pending_r       <= DEF_C;
                pending_valid_r <= 1'b1;
            end else if (switch_s) begin
                pending_valid_r <= 1'b0;
            end else begin
                pending_valid_r <= pending_valid_r;
            end
            if ((TIMEOUT_CYC == 0) || timer_clr_s) begin
                timer_r <= {TMR_W{1'b0}};
            end else if (timer_r != {TMR_W{1'b1}}) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
            if (switch_s) begin
                active_scene_r <= pending_r;
                scene_en_r     <= onehot_f(pending_r);
            end else begin
                active_scene_r <= active_scene_r;
                scene_en_r     <= scene_en_r;
            end
            pix_out_r       <= pix_sel_s;
            switch_pulse_r  <= switch_s;
            timeout_pulse_r <= timeout_s;
        end
    end

    assign pix_out       = pix_out_r;
    assign active_scene  = active_scene_r;
    assign scene_en      = scene_en_r;
    assign switch_pulse  = switch_pulse_r;
    assign timeout_pulse = timeout_pulse_r;

endmodule

// File: tb/tb_scene_display_controller.sv
// Directed bench for scene_display_controller: a frame-synchronous instance with a
// short idle timeout, and an immediate-switch instance with the timeout disabled.
module tb_scene_display_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   addr_x;
    logic [7:0]   addr_y;
    logic [127:0] pix_in;
    logic [7:0]   req;
    logic         activity;

    logic [15:0]  pix_out_a, pix_out_b;
    logic [2:0]   active_a, active_b;
    logic [7:0]   scene_en_a, scene_en_b;
    logic         switch_a, switch_b;
    logic         timeout_a, timeout_b;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    scene_display_controller #(.TIMEOUT_CYC(100), .SYNC_SWITCH(1)) u_dut_sync (
        .clk(clk), .rst(rst), .addr_x(addr_x), .addr_y(addr_y), .pix_in(pix_in),
        .req(req), .activity(activity), .pix_out(pix_out_a), .active_scene(active_a),
        .scene_en(scene_en_a), .switch_pulse(switch_a), .timeout_pulse(timeout_a)
    );

    scene_display_controller #(.TIMEOUT_CYC(0), .SYNC_SWITCH(0)) u_dut_async (
        .clk(clk), .rst(rst), .addr_x(addr_x), .addr_y(addr_y), .pix_in(pix_in),
        .req(req), .activity(activity), .pix_out(pix_out_b), .active_scene(active_b),
        .scene_en(scene_en_b), .switch_pulse(switch_b), .timeout_pulse(timeout_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int k);
        logic [15:0] base;
        base = 16'h1111;
        return 16'(base * 16'(k + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int x, input int y);
        addr_x = 8'(x);
        addr_y = 8'(y);
    endtask

    initial begin
        int cnt;
        int first;
        rst = 1'b1; req = 8'h00; activity = 1'b0; set_addr(0, 0);
        for (int k = 0; k < 8; k++) pix_in[k*16 +: 16] = exp_pix(k);

        // Reset state
        tick(); tick();
        check_eq("rst_active", 32'(active_a), 32'd0);
        check_eq("rst_scene_en", 32'(scene_en_a), 32'h01);
        check_eq("rst_pix", 32'(pix_out_a), 32'h0);
        check_eq("rst_switch", 32'(switch_a), 32'd0);
        check_eq("rst_timeout", 32'(timeout_a), 32'd0);
        check_eq("rst_active_b", 32'(active_b), 32'd0);
        rst = 1'b0; activity = 1'b1;
        tick();
        check_eq("pix_scene0", 32'(pix_out_a), 32'(exp_pix(0)));

        // Mid-frame request commits only at the wrap to (0,0)
        set_addr(40, 50); req = 8'h08;
        tick(); req = 8'h00;
        repeat (5) tick();
        check_eq("hold_mid_frame", 32'(active_a), 32'd0);
        check_eq("no_early_switch", 32'(switch_a), 32'd0);
        set_addr(0, 0);
        tick();
        check_eq("commit_pulse", 32'(switch_a), 32'd1);
        check_eq("commit_scene3", 32'(active_a), 32'd3);
        check_eq("commit_en3", 32'(scene_en_a), 32'h08);
        tick();
        check_eq("pulse_one_cycle", 32'(switch_a), 32'd0);
        check_eq("pix_scene3", 32'(pix_out_a), 32'(exp_pix(3)));

        // Request for the current scene cancels a pending switch
        rst = 1'b1; tick(); rst = 1'b0;
        set_addr(10, 10); req = 8'h24;
        tick(); req = 8'h01;
        tick(); req = 8'h00;
        tick(); tick();
        set_addr(0, 0);
        tick();
        check_eq("cancel_no_pulse", 32'(switch_a), 32'd0);
        tick();
        check_eq("cancel_scene0", 32'(active_a), 32'd0);

        // Simultaneous requests: highest index wins
        set_addr(10, 10); req = 8'h24;
        tick(); req = 8'h00;
        tick(); tick();
        set_addr(0, 0);
        tick();
        check_eq("prio_pulse", 32'(switch_a), 32'd1);
        check_eq("prio_scene5", 32'(active_a), 32'd5);
        check_eq("prio_en5", 32'(scene_en_a), 32'h20);

        // Reset while waiting for the boundary discards the pending switch
        set_addr(10, 10); req = 8'h40;
        tick(); req = 8'h00;
        tick(); tick();
        rst = 1'b1; tick();
        check_eq("rst_wait_scene", 32'(active_a), 32'd0);
        check_eq("rst_wait_en", 32'(scene_en_a), 32'h01);
        rst = 1'b0; tick();
        set_addr(0, 0);
        tick();
        check_eq("rst_wait_no_pulse", 32'(switch_a), 32'd0);
        tick();
        check_eq("rst_wait_stay0", 32'(active_a), 32'd0);

        // Address parked at (0,0) gives exactly one commit
        set_addr(10, 10); req = 8'h80;
        tick(); req = 8'h00;
        tick();
        set_addr(0, 0);
        cnt = 0;
        repeat (500) begin
            tick();
            if (switch_a) cnt++;
        end
        check_eq("held_addr_commits", 32'(cnt), 32'd1);
        check_eq("held_addr_scene7", 32'(active_a), 32'd7);

        // Idle timeout from scene 4 with no activity
        rst = 1'b1; tick(); rst = 1'b0; activity = 1'b0;
        set_addr(10, 10); req = 8'h10;
        tick(); req = 8'h00;
        tick();
        set_addr(0, 0);
        tick();
        check_eq("to_commit4", 32'(active_a), 32'd4);
        cnt = 0; first = -1;
        for (int s = 1; s <= 110; s++) begin
            tick();
            if (timeout_a) begin
                cnt++;
                if (first < 0) first = s;
            end
        end
        check_eq("to_first_cycle", 32'(first), 32'd101);
        check_eq("to_pulse_count", 32'(cnt), 32'd1);
        check_eq("to_wait_frame", 32'(active_a), 32'd4);
        set_addr(10, 10); tick();
        set_addr(0, 0); tick();
        check_eq("to_revert_pulse", 32'(switch_a), 32'd1);
        check_eq("to_revert_scene0", 32'(active_a), 32'd0);

        // Activity at cycle 60 restarts the idle timer
        set_addr(10, 10); req = 8'h10;
        tick(); req = 8'h00;
        tick();
        set_addr(0, 0);
        tick();
        check_eq("act_commit4", 32'(active_a), 32'd4);
        cnt = 0; first = -1;
        for (int s = 1; s <= 200; s++) begin
            tick();
            if (timeout_a) begin
                cnt++;
                if (first < 0) first = s;
            end
            activity = (s == 60);
        end
        check_eq("act_first_cycle", 32'(first), 32'd161);
        check_eq("act_pulse_count", 32'(cnt), 32'd1);

        // Immediate-switch instance: commit two cycles after the request
        rst = 1'b1; tick(); rst = 1'b0; activity = 1'b1;
        set_addr(10, 10); tick();
        req = 8'h40;
        tick(); req = 8'h00;
        check_eq("async_not_yet", 32'(active_b), 32'd0);
        check_eq("async_no_pulse", 32'(switch_b), 32'd0);
        tick();
        check_eq("async_scene6", 32'(active_b), 32'd6);
        check_eq("async_pulse", 32'(switch_b), 32'd1);
        check_eq("async_en6", 32'(scene_en_b), 32'h40);
        tick();
        check_eq("async_pulse_end", 32'(switch_b), 32'd0);
        check_eq("async_pix6", 32'(pix_out_b), 32'(exp_pix(6)));
        check_eq("async_no_timeout", 32'(timeout_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
